// File: rtl/gsim_param.sv
`default_nettype none
// ============================================================================
// Module   : gsim_param
// Purpose  : Parametrised in-place Gauss-Seidel solver for the N-unknown banded
//            DSD system, with iteration limit, tolerance stop and output backpressure.
// Revision : 1.0
// ============================================================================
module gsim_param #(
    parameter int N      = 16,
    parameter int B_W    = 16,
    parameter int X_W    = 32,
    parameter int ITER_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_en,
    input  logic [B_W-1:0]    b_in,
    input  logic [ITER_W-1:0] iter_max,
    input  logic [X_W-1:0]    tol,
    input  logic              out_ready,
    output logic              busy,
    output logic              out_valid,
    output logic [X_W-1:0]    x_out,
    output logic [ITER_W-1:0] out_iter,
    output logic              converged
);

    localparam int IDX_W = $clog2(N);
    // Sum width covers b*2^16 plus 40*|x| with margin, so nothing wraps.
    localparam int S_W = (X_W + 8 > B_W + 22) ? X_W + 8 : B_W + 22;
    localparam logic [IDX_W-1:0]     LAST = IDX_W'(N - 1);
    localparam logic signed [S_W-1:0] C13 = S_W'(13);
    localparam logic signed [S_W-1:0] C6  = S_W'(6);
    localparam logic signed [S_W-1:0] C20 = S_W'(20);
    localparam logic signed [S_W-1:0] ONE = S_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_OUT} state_t;

    state_t                 state_q;
    logic signed [X_W-1:0]  x_q [N];
    logic signed [B_W-1:0]  b_q [N];
    logic [IDX_W-1:0]       ld_q, i_q, k_q;
    logic [ITER_W-1:0]      sweeps_q, itmax_q, out_iter_q;
    logic [X_W-1:0]         tol_q, d_q, x_out_q;
    logic                   conv_q;

    logic signed [X_W-1:0]  xm1, xm2, xm3, xp1, xp2, xp3, xold;
    logic signed [B_W-1:0]  bcur;

    always_comb begin
        xm1 = '0; xm2 = '0; xm3 = '0;
        xp1 = '0; xp2 = '0; xp3 = '0;
        xold = '0; bcur = '0;
        for (int j = 0; j < N; j++) begin
            if (j + 1 == int'(i_q)) xm1 = x_q[j];
            if (j + 2 == int'(i_q)) xm2 = x_q[j];
            if (j + 3 == int'(i_q)) xm3 = x_q[j];
            if (j - 1 == int'(i_q)) xp1 = x_q[j];
            if (j - 2 == int'(i_q)) xp2 = x_q[j];
            if (j - 3 == int'(i_q)) xp3 = x_q[j];
            if (j == int'(i_q)) begin
                xold = x_q[j];
                bcur = b_q[j];
            end
        end
    end

    logic signed [S_W-1:0] s_d, q_d, r_d, fl_d;
    logic [S_W-X_W:0]      hi_d;
    logic signed [X_W-1:0] xnew_d;
    logic signed [X_W:0]   diff_d;
    logic [X_W-1:0]        dabs_d, dmax_d;
    logic [ITER_W-1:0]     sw_next_d;
    logic                  tol_hit_d, iter_hit_d;

    assign s_d = (S_W'(bcur) <<< 16)
               + C13 * (S_W'(xm1) + S_W'(xp1))
               - C6  * (S_W'(xm2) + S_W'(xp2))
               + S_W'(xm3) + S_W'(xp3);
    // Division truncates toward zero; step down once for negative inexact quotients.
    assign q_d    = s_d / C20;
    assign r_d    = s_d % C20;
    assign fl_d   = ((|r_d) && s_d[S_W-1]) ? q_d - ONE : q_d;
    assign hi_d   = fl_d[S_W-1:X_W-1];
    assign xnew_d = ((&hi_d) || !(|hi_d)) ? fl_d[X_W-1:0]
                  : (fl_d[S_W-1] ? {1'b1, {(X_W-1){1'b0}}} : {1'b0, {(X_W-1){1'b1}}});

    assign diff_d     = {xnew_d[X_W-1], xnew_d} - {xold[X_W-1], xold};
    assign dabs_d     = diff_d[X_W] ? X_W'(-diff_d) : X_W'(diff_d);
    assign dmax_d     = (dabs_d > d_q) ? dabs_d : d_q;
    assign sw_next_d  = sweeps_q + ITER_W'(1);
    assign tol_hit_d  = (tol_q != '0) && (dmax_d <= tol_q);
    assign iter_hit_d = (sw_next_d == itmax_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            for (int j = 0; j < N; j++) begin
                x_q[j] <= '0;
                b_q[j] <= '0;
            end
            ld_q       <= '0;
            i_q        <= '0;
            k_q        <= '0;
            sweeps_q   <= '0;
            itmax_q    <= '0;
            out_iter_q <= '0;
            tol_q      <= '0;
            d_q        <= '0;
            x_out_q    <= '0;
            conv_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_en) begin
                        b_q[0]     <= b_in;
                        for (int j = 0; j < N; j++) x_q[j] <= '0;
                        ld_q       <= IDX_W'(1);
                        itmax_q    <= (iter_max == '0) ? ITER_W'(1) : iter_max;
                        tol_q      <= tol;
                        out_iter_q <= '0;
                        conv_q     <= 1'b0;
                        state_q    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_en) begin
                        b_q[ld_q] <= b_in;
                        if (ld_q == LAST) begin
                            i_q      <= '0;
                            sweeps_q <= '0;
                            d_q      <= '0;
                            state_q  <= S_CALC;
                        end else begin
                            ld_q <= ld_q + IDX_W'(1);
                        end
                    end
                end
                S_CALC: begin
                    x_q[i_q] <= xnew_d;
                    if (i_q == LAST) begin
                        d_q <= '0;
                        i_q <= '0;
                        if (tol_hit_d || iter_hit_d) begin
                            out_iter_q <= sw_next_d;
                            conv_q     <= tol_hit_d;
                            k_q        <= '0;
                            x_out_q    <= x_q[0];
                            state_q    <= S_OUT;
                        end else begin
                            sweeps_q <= sw_next_d;
                        end
                    end else begin
                        i_q <= i_q + IDX_W'(1);
                        d_q <= dmax_d;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        if (k_q == LAST) begin
                            x_out_q <= '0;
                            state_q <= S_IDLE;
                        end else begin
                            k_q     <= k_q + IDX_W'(1);
                            x_out_q <= x_q[k_q + IDX_W'(1)];
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_OUT);
    assign x_out     = x_out_q;
    assign out_iter  = out_iter_q;
    assign converged = conv_q;

endmodule
`default_nettype wire
